// File: rtl/multi_rate_sampler.sv
// multi_rate_sampler: decimates qualified ext_trig events into a base
// strobe (sample_out) plus up to three further-decimated strobes.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   ext_trig            input event qualifier
//   sample_period       ext_trig events per sample_out (0 = off)
//   dsampleN_period     sample_out events per dsampleN_stb (0 = off)
//   sample_out          registered 1-cycle base strobe
//   dsampleN_stb        registered 1-cycle decimated strobes

// decim_stage: one modulo-P event counter.
//   adv_i     advance qualifier for this cycle
//   period_i  events per output event; 0 clears and disables
//   evt_o     combinational: this advance completes a period
module decim_stage #(
   parameter int WI = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          adv_i,
   input  logic [WI-1:0] period_i,
   output logic          evt_o
);

   logic [WI-1:0] cnt_q;
   logic [WI-1:0] cnt_d;
   logic          off;

   assign off = (period_i == '0);

   // ">=" rather than "==" so a period lowered below the running
   // count fires on the next advance instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      evt_o = 1'b0;
      if (off) begin
         cnt_d = '0;
      end else if (adv_i) begin
         if (cnt_q >= period_i - WI'(1)) begin
            evt_o = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + WI'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

module multi_rate_sampler #(
   parameter int sample_period_wi = 8,
   parameter bit dsample0_en      = 1'b1,
   parameter int dsample0_wi      = 8,
   parameter bit dsample1_en      = 1'b0,
   parameter int dsample1_wi      = 8,
   parameter bit dsample2_en      = 1'b0,
   parameter int dsample2_wi      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ext_trig,
   input  logic [sample_period_wi-1:0] sample_period,
   input  logic [dsample0_wi-1:0]      dsample0_period,
   input  logic [dsample1_wi-1:0]      dsample1_period,
   input  logic [dsample2_wi-1:0]      dsample2_period,
   output logic                        sample_out,
   output logic                        dsample0_stb,
   output logic                        dsample1_stb,
   output logic                        dsample2_stb
);

   logic base_evt;
   logic sample_q;
   logic sample_d;

   decim_stage #(
      .WI(sample_period_wi)
   ) u_base (
      .clk     (clk),
      .reset   (reset),
      .adv_i   (ext_trig),
      .period_i(sample_period),
      .evt_o   (base_evt)
   );

   assign sample_d = base_evt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q <= 1'b0;
      end else begin
         sample_q <= sample_d;
      end
   end

   assign sample_out = sample_q;

   // Decimated stages only advance on base events, so every stage
   // strobe lands on a cycle that also carries sample_out.
   generate
      if (dsample0_en) begin : g_ds0
         logic evt;
         logic stb_q;
         logic stb_d;
         decim_stage #(
            .WI(dsample0_wi)
         ) u_ds0 (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (base_evt),
            .period_i(dsample0_period),
            .evt_o   (evt)
         );
         assign stb_d = evt;
         always_ff @(posedge clk) begin
            if (reset) begin
               stb_q <= 1'b0;
            end else begin
               stb_q <= stb_d;
            end
         end
         assign dsample0_stb = stb_q;
      end else begin : g_no_ds0
         logic unused_ds0;
         assign unused_ds0   = ^dsample0_period;
         assign dsample0_stb = 1'b0;
      end

      if (dsample1_en) begin : g_ds1
         logic evt;
         logic stb_q;
         logic stb_d;
         decim_stage #(
            .WI(dsample1_wi)
         ) u_ds1 (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (base_evt),
            .period_i(dsample1_period),
            .evt_o   (evt)
         );
         assign stb_d = evt;
         always_ff @(posedge clk) begin
            if (reset) begin
               stb_q <= 1'b0;
            end else begin
               stb_q <= stb_d;
            end
         end
         assign dsample1_stb = stb_q;
      end else begin : g_no_ds1
         logic unused_ds1;
         assign unused_ds1   = ^dsample1_period;
         assign dsample1_stb = 1'b0;
      end

      if (dsample2_en) begin : g_ds2
         logic evt;
         logic stb_q;
         logic stb_d;
         decim_stage #(
            .WI(dsample2_wi)
         ) u_ds2 (
            .clk     (clk),
            .reset   (reset),
            .adv_i   (base_evt),
            .period_i(dsample2_period),
            .evt_o   (evt)
         );
         assign stb_d = evt;
         always_ff @(posedge clk) begin
            if (reset) begin
               stb_q <= 1'b0;
            end else begin
               stb_q <= stb_d;
            end
         end
         assign dsample2_stb = stb_q;
      end else begin : g_no_ds2
         logic unused_ds2;
         assign unused_ds2   = ^dsample2_period;
         assign dsample2_stb = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_multi_rate_sampler.sv
// tb_multi_rate_sampler: default-parameter instance plus a narrow
// all-stages instance, both checked against trigger-count arithmetic.
module tb_multi_rate_sampler;

   logic       clk;
   logic       reset;
   logic       ext_trig;

   logic [7:0] sp1, d0p1, d1p1, d2p1;
   logic       so1, ds0_1, ds1_1, ds2_1;

   logic [3:0] sp2, d0p2, d1p2, d2p2;
   logic       so2, ds0_2, ds1_2, ds2_2;

   int n_chk;
   int n_pass;

   // model state: triggers and base events since reset
   int t1, b1, t2, b2;
   logic e_so1, e_d0_1;
   logic e_so2, e_d0_2, e_d1_2, e_d2_2;

   multi_rate_sampler u_dut1 (
      .clk            (clk),
      .reset          (reset),
      .ext_trig       (ext_trig),
      .sample_period  (sp1),
      .dsample0_period(d0p1),
      .dsample1_period(d1p1),
      .dsample2_period(d2p1),
      .sample_out     (so1),
      .dsample0_stb   (ds0_1),
      .dsample1_stb   (ds1_1),
      .dsample2_stb   (ds2_1)
   );

   multi_rate_sampler #(
      .sample_period_wi(4),
      .dsample0_en     (1'b1),
      .dsample0_wi     (4),
      .dsample1_en     (1'b1),
      .dsample1_wi     (4),
      .dsample2_en     (1'b1),
      .dsample2_wi     (4)
   ) u_dut2 (
      .clk            (clk),
      .reset          (reset),
      .ext_trig       (ext_trig),
      .sample_period  (sp2),
      .dsample0_period(d0p2),
      .dsample1_period(d1p2),
      .dsample2_period(d2p2),
      .sample_out     (so2),
      .dsample0_stb   (ds0_2),
      .dsample1_stb   (ds1_2),
      .dsample2_stb   (ds2_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got,
                      input logic exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0b expected=%0b at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // The k-th trigger since reset completes a base period when
   // k is a multiple of P; likewise the m-th base event for stage N.
   function automatic logic hit(input int n, input int p);
      return (p != 0) && (n % p == 0);
   endfunction

   task automatic model(input logic r, input logic t);
      e_so1 = 0; e_d0_1 = 0;
      e_so2 = 0; e_d0_2 = 0; e_d1_2 = 0; e_d2_2 = 0;
      if (r) begin
         t1 = 0; b1 = 0; t2 = 0; b2 = 0;
      end else if (t) begin
         if (sp1 != 0) begin
            t1++;
            if (hit(t1, int'(sp1))) begin
               e_so1 = 1;
               b1++;
               e_d0_1 = hit(b1, int'(d0p1));
            end
         end
         if (sp2 != 0) begin
            t2++;
            if (hit(t2, int'(sp2))) begin
               e_so2 = 1;
               b2++;
               e_d0_2 = hit(b2, int'(d0p2));
               e_d1_2 = hit(b2, int'(d1p2));
               e_d2_2 = hit(b2, int'(d2p2));
            end
         end
      end
   endtask

   // Called at a negedge: apply inputs, let a posedge pass, check
   // registered outputs at the following negedge.
   task automatic step(input logic r, input logic t);
      reset    = r;
      ext_trig = t;
      model(r, t);
      @(negedge clk);
      chk("so1", so1, e_so1);
      chk("ds0_1", ds0_1, e_d0_1);
      chk("ds1_1_off", ds1_1, 1'b0);
      chk("ds2_1_off", ds2_1, 1'b0);
      chk("so2", so2, e_so2);
      chk("ds0_2", ds0_2, e_d0_2);
      chk("ds1_2", ds1_2, e_d1_2);
      chk("ds2_2", ds2_2, e_d2_2);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      t1 = 0; b1 = 0; t2 = 0; b2 = 0;
      reset = 1; ext_trig = 0;
      sp1 = 2; d0p1 = 1; d1p1 = 8'hff; d2p1 = 8'h01;
      sp2 = 15; d0p2 = 2; d1p2 = 3; d2p2 = 1;

      // reset with trigger held high: no strobes
      step(1, 1);
      step(1, 1);

      // trig held high, P=2, D0=1
      for (int i = 0; i < 40; i++) step(0, 1);

      // trig every 3rd cycle, P=4, D0=3
      sp1 = 4; d0p1 = 3; sp2 = 4; d0p2 = 3;
      step(1, 0);
      for (int i = 0; i < 120; i++) step(0, (i % 3) == 0);

      // period 0 then 1 without reset
      sp1 = 0; sp2 = 0; d0p1 = 1; d0p2 = 1;
      step(1, 0);
      for (int i = 0; i < 10; i++) step(0, 1);
      sp1 = 1; sp2 = 1;
      for (int i = 0; i < 10; i++) step(0, 1);

      // reset mid-count (bcnt=3, P=5) with trig high
      sp1 = 5; sp2 = 5;
      step(1, 0);
      for (int i = 0; i < 3; i++) step(0, 1);
      step(1, 1);
      for (int i = 0; i < 12; i++) step(0, 1);

      // lower D0 from 8 to 2 while dcnt0=5
      sp1 = 1; d0p1 = 8; sp2 = 1; d0p2 = 8;
      step(1, 0);
      for (int i = 0; i < 5; i++) step(0, 1);
      d0p1 = 2; d0p2 = 2;
      for (int i = 0; i < 10; i++) step(0, 1);

      // 4-bit base at full-scale period
      sp2 = 15; d0p2 = 2; d1p2 = 15; d2p2 = 1;
      step(1, 0);
      for (int i = 0; i < 300; i++) step(0, 1);

      // randomized segments, constant periods within a segment
      for (int s = 0; s < 24; s++) begin
         int pct;
         sp1  = 8'($urandom_range(0, 6));
         d0p1 = 8'($urandom_range(0, 4));
         sp2  = 4'($urandom_range(0, 15));
         d0p2 = 4'($urandom_range(0, 3));
         d1p2 = 4'($urandom_range(0, 3));
         d2p2 = 4'($urandom_range(0, 5));
         pct  = int'($urandom_range(20, 100));
         step(1, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 60; i++) begin
            step(0, $urandom_range(1, 100) <= pct);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_rate_sampler.md
# multi_rate_sampler

Strobe generator that decimates a qualified input event stream into a base sample strobe and up to three further-decimated strobes. It sits ahead of multichannel CIC recorders: `sample_out` drives the CIC integrator-dump strobe, and the `dsampleN_stb` outputs drive the downstream filter and channel-selector sample strobes. All strobes are single-cycle pulses, aligned to one clock.

## Interface
Parameters:
- `sample_period_wi`, 8: width of `sample_period` and of the base counter.
- `dsample0_en`, 1: 1 instantiates decimated stage 0; 0 ties `dsample0_stb` low and removes its logic.
- `dsample0_wi`, 8: width of `dsample0_period` and of its counter.
- `dsample1_en`, 0; `dsample1_wi`, 8: same meaning for stage 1.
- `dsample2_en`, 0; `dsample2_wi`, 8: same meaning for stage 2.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ext_trig`  in  1  input event qualifier; may be held high continuously.
- `sample_period`  in  `sample_period_wi`  number of `ext_trig` events per `sample_out`.
- `dsample0_period`  in  `dsample0_wi`  number of `sample_out` events per `dsample0_stb`.
- `dsample1_period`  in  `dsample1_wi`  same for stage 1.
- `dsample2_period`  in  `dsample2_wi`  same for stage 2.
- `sample_out`  out  1  base decimated strobe, registered.
- `dsample0_stb`, `dsample1_stb`, `dsample2_stb`  out  1 each  decimated strobes, registered.

## Operation
- Base counter `bcnt` (`sample_period_wi` bits):
  - Advances only on cycles with `ext_trig`=1.
  - On such a cycle, if `sample_period` ≠ 0 and `bcnt` ≥ `sample_period`−1, the cycle is a base event: `bcnt` is set to 0.
  - Otherwise, if `sample_period` ≠ 0, `bcnt` increments by 1.
- `sample_period` = 0 disables the base stage: `bcnt` is held at 0, `sample_out` and all `dsampleN_stb` stay 0.
- Period P ≥ 1 gives exactly one base event per P `ext_trig` cycles. P = 1 gives a base event on every `ext_trig`.
- Stage N (only when `dsampleN_en`=1) has its own counter `dcntN` (`dsampleN_wi` bits) that advances only on base events, using the same compare/reset rule against `dsampleN_period`.
  - A stage-N event is a base event on which `dcntN` ≥ `dsampleN_period`−1.
  - `dsampleN_period` = 0 disables that stage only.
- Outputs, registered:
  - `sample_out` is 1 on the cycle after each base event.
  - `dsampleN_stb` is 1 on the cycle after each stage-N event.
  - Every `dsampleN_stb` pulse therefore coincides with a `sample_out` pulse.
- Periods are sampled live. Lowering a period below the current count fires on the next qualifying event; no other glitch handling is provided.

## Timing
- Reset (synchronous, dominates `ext_trig`):
  - All counters go to 0.
  - `sample_out` and all `dsampleN_stb` are 0 in the cycle after `reset` is sampled high.
- Reset mid-count discards partial counts.
- After reset release with period P, the first `sample_out` comes one cycle after the P-th `ext_trig`.
- Latency: qualifying `ext_trig` edge → strobe high is 1 clock, and strobes last exactly 1 clock.
- Maximum strobe rate is one per clock (P = 1 with `ext_trig` held high).
- Counter wrap: the counter never exceeds `period`−1 unless the period was just lowered. In that case it is cleared on the next qualifying event; it never wraps past 2^wi−1.
- No handshake or back-pressure: outputs are free-running pulses.

## Test plan
- `ext_trig` held high, `sample_period`=2, `dsample0_period`=1 → `sample_out` and `dsample0_stb` both pulse on alternate cycles, first pulse 2 cycles after reset release; `dsample1_stb` and `dsample2_stb` (en=0) stay 0.
- `ext_trig` high every 3rd cycle, `sample_period`=4, `dsample0_period`=3 → `sample_out` every 12 cycles, `dsample0_stb` every 36 cycles, always coincident with a `sample_out`.
- `sample_period`=0 with `ext_trig` high → no pulses on any output; then set it to 1 → `sample_out` pulses every cycle starting the cycle after the first `ext_trig` under period 1.
- `reset` asserted mid-count (`bcnt`=3, P=5) together with `ext_trig`=1 → no pulse; after release, 5 more `ext_trig` cycles are needed for the next `sample_out`.
- `dsample0_period` changed 8→2 while `dcnt0`=5 → `dsample0_stb` fires on the next base event, then every 2 base events.
- Widths: `sample_period_wi`=4, `sample_period`=15 → a pulse every 15 triggers, with no counter overflow.
